// File: rtl/twiddle_read_sched.sv
// Twiddle / Rader-precompute register-file read sequencer.
// A job (mode plus pass count) is latched in IDLE. The block then streams
// beats to the butterfly datapath under valid/ready. Each beat carries the
// register-file select, eight lane read addresses and the DFT phase bit.
// Every output comes from a flop. Each output register is loaded from the
// next-state view, so outputs change in the same cycle as the state.
module twiddle_read_sched #(
  parameter int IDX_W     = 6,
  parameter int DFT_BEATS = 2,
  parameter int PASS_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic [PASS_W-1:0] num_passes,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [2:0]        sel_o,
  output logic [IDX_W-1:0]  rd_addr0,
  output logic [IDX_W-1:0]  rd_addr1,
  output logic [IDX_W-1:0]  rd_addr2,
  output logic [IDX_W-1:0]  rd_addr3,
  output logic [IDX_W-1:0]  rd_addr4,
  output logic [IDX_W-1:0]  rd_addr5,
  output logic [IDX_W-1:0]  rd_addr6,
  output logic [IDX_W-1:0]  rd_addr7,
  output logic              m1_out_0_o,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Beats per pass for each job mode.
  function automatic logic [IDX_W-1:0] beats_per_pass(input logic [2:0] m);
    logic [IDX_W-1:0] b;
    case (m)
      3'd1:    b = IDX_W'(6);
      3'd2:    b = IDX_W'(5);
      3'd3:    b = IDX_W'(12);
      3'd4:    b = IDX_W'(DFT_BEATS);
      3'd5:    b = IDX_W'(DFT_BEATS);
      default: b = IDX_W'(1);
    endcase
    return b;
  endfunction

  // Number of lanes that carry a non-zero address in the Rader modes.
  function automatic logic [3:0] active_lanes(input logic [2:0] m);
    logic [3:0] n;
    case (m)
      3'd1:    n = 4'd5;
      3'd2:    n = 4'd8;
      3'd3:    n = 4'd5;
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  // Modes 1..5 are the only legal job types.
  function automatic logic mode_legal(input logic [2:0] m);
    return (m >= 3'd1) && (m <= 3'd5);
  endfunction

  state_t            state_r, state_nxt;
  logic [2:0]        mode_r, mode_nxt;
  logic [PASS_W-1:0] passes_r, passes_nxt;
  logic [PASS_W-1:0] pass_r, pass_nxt;
  logic [IDX_W-1:0]  beat_r, beat_nxt;
  logic [IDX_W-1:0]  bpp_s;
  logic [IDX_W-1:0]  bpp_nxt_s;
  logic [3:0]        lanes_nxt_s;
  logic              accept_s;
  logic              last_beat_s;

  logic              valid_nxt, done_nxt, err_nxt, busy_nxt, m1_nxt;
  logic [2:0]        sel_nxt;
  logic [IDX_W-1:0]  addr_nxt [8];
  logic [IDX_W-1:0]  addr_r   [8];

  assign bpp_s       = beats_per_pass(mode_r);
  assign accept_s    = out_valid && out_ready;
  assign last_beat_s = (beat_r == (bpp_s - IDX_W'(1))) &&
                       (pass_r == (passes_r - PASS_W'(1)));

  // Next-state and counter logic; flush overrides everything.
  always_comb begin
    state_nxt  = state_r;
    mode_nxt   = mode_r;
    passes_nxt = passes_r;
    pass_nxt   = pass_r;
    beat_nxt   = beat_r;
    valid_nxt  = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    if (flush) begin
      state_nxt = ST_IDLE;
      pass_nxt  = '0;
      beat_nxt  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (mode_legal(mode)) begin
              state_nxt  = ST_RUN;
              mode_nxt   = mode;
              passes_nxt = (num_passes == '0) ? PASS_W'(1) : num_passes;
              pass_nxt   = '0;
              beat_nxt   = '0;
              valid_nxt  = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          valid_nxt = 1'b1;
          if (accept_s) begin
            if (last_beat_s) begin
              state_nxt = ST_DONE;
              valid_nxt = 1'b0;
              done_nxt  = 1'b1;
              pass_nxt  = '0;
              beat_nxt  = '0;
            end else if (beat_r == (bpp_s - IDX_W'(1))) begin
              beat_nxt = '0;
              pass_nxt = pass_r + PASS_W'(1);
            end else begin
              beat_nxt = beat_r + IDX_W'(1);
            end
          end else begin
            beat_nxt = beat_r;
          end
        end
        ST_DONE: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
          pass_nxt  = '0;
          beat_nxt  = '0;
        end
      endcase
    end
  end

  assign bpp_nxt_s   = beats_per_pass(mode_nxt);
  assign lanes_nxt_s = active_lanes(mode_nxt);

  // Beat payload for the next cycle: lane k reads k*B + b in the Rader modes.
  always_comb begin
    busy_nxt = (state_nxt != ST_IDLE);
    sel_nxt  = 3'd0;
    m1_nxt   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      addr_nxt[k] = '0;
    end
    if (state_nxt == ST_RUN) begin
      sel_nxt = mode_nxt;
      if (mode_nxt == 3'd4) begin
        m1_nxt = beat_nxt[0];
      end else begin
        m1_nxt = 1'b0;
      end
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < lanes_nxt_s) begin
          addr_nxt[k] = IDX_W'(k) * bpp_nxt_s + beat_nxt;
        end else begin
          addr_nxt[k] = '0;
        end
      end
    end else begin
      sel_nxt = 3'd0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      mode_r     <= 3'd0;
      passes_r   <= '0;
      pass_r     <= '0;
      beat_r     <= '0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      sel_o      <= 3'd0;
      m1_out_0_o <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        addr_r[k] <= '0;
      end
    end else begin
      state_r    <= state_nxt;
      mode_r     <= mode_nxt;
      passes_r   <= passes_nxt;
      pass_r     <= pass_nxt;
      beat_r     <= beat_nxt;
      out_valid  <= valid_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      busy       <= busy_nxt;
      sel_o      <= sel_nxt;
      m1_out_0_o <= m1_nxt;
      for (int k = 0; k < 8; k++) begin
        addr_r[k] <= addr_nxt[k];
      end
    end
  end

  assign rd_addr0 = addr_r[0];
  assign rd_addr1 = addr_r[1];
  assign rd_addr2 = addr_r[2];
  assign rd_addr3 = addr_r[3];
  assign rd_addr4 = addr_r[4];
  assign rd_addr5 = addr_r[5];
  assign rd_addr6 = addr_r[6];
  assign rd_addr7 = addr_r[7];

endmodule

// File: tb/tb_twiddle_read_sched.sv
// Directed bench for twiddle_read_sched: table of whole jobs plus
// hand-written error, flush and asynchronous-reset sequences.
module tb_twiddle_read_sched;
  localparam int IDX_W = 6;
  localparam int DFT_BEATS = 2;
  localparam int PASS_W = 8;

  logic clk = 1'b0;
  logic rst_n, start, flush, out_ready;
  logic [2:0] mode;
  logic [PASS_W-1:0] num_passes;
  logic out_valid, m1_out_0_o, busy, done, err;
  logic [2:0] sel_o;
  logic [IDX_W-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [IDX_W-1:0] rd_addr4, rd_addr5, rd_addr6, rd_addr7;

  int checks = 0;
  int failures = 0;

  twiddle_read_sched #(.IDX_W(IDX_W), .DFT_BEATS(DFT_BEATS), .PASS_W(PASS_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_passes(num_passes),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid), .sel_o(sel_o),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rd_addr4(rd_addr4), .rd_addr5(rd_addr5), .rd_addr6(rd_addr6), .rd_addr7(rd_addr7),
    .m1_out_0_o(m1_out_0_o), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        mode;
    logic [PASS_W-1:0] passes;
    bit                toggle;
    int                exp_acc;
    int                mid_idx;
    logic [47:0]       exp_first;
    logic [47:0]       exp_mid;
    logic [47:0]       exp_last;
    logic [15:0]       exp_m1;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] mk(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    return {6'(a7), 6'(a6), 6'(a5), 6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  function automatic logic [47:0] cur_addr();
    return {rd_addr7, rd_addr6, rd_addr5, rd_addr4, rd_addr3, rd_addr2, rd_addr1, rd_addr0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job and reports what was seen at each acceptance.
  task automatic run_job(input vec_t v, output int acc, output logic [47:0] first,
                         output logic [47:0] mid, output logic [47:0] last,
                         output logic [15:0] m1, output bit sel_ok, output bit stable_ok,
                         output int lag, output int dones);
    int last_acc_cyc;
    int done_cyc;
    logic [47:0] prev_addr;
    logic [2:0] prev_sel;
    logic prev_m1;
    bit stalled;
    last_acc_cyc = -1; done_cyc = -1; stalled = 1'b0;
    prev_addr = '0; prev_sel = 3'd0; prev_m1 = 1'b0;
    acc = 0; first = '0; mid = '0; last = '0; m1 = '0;
    sel_ok = 1'b1; stable_ok = 1'b1; dones = 0;
    mode = v.mode; num_passes = v.passes; start = 1'b1; out_ready = 1'b0;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc > done_cyc) break;
      if (stalled && (cur_addr() !== prev_addr || sel_o !== prev_sel ||
                      m1_out_0_o !== prev_m1 || out_valid !== 1'b1)) stable_ok = 1'b0;
      out_ready = v.toggle ? (cyc % 2 == 1) : 1'b1;
      if (out_valid) begin
        if (sel_o !== v.mode) sel_ok = 1'b0;
        if (out_ready) begin
          if (acc == 0) first = cur_addr();
          if (acc == v.mid_idx) mid = cur_addr();
          last = cur_addr();
          if (acc < 16) m1[acc] = m1_out_0_o;
          acc++;
          last_acc_cyc = cyc;
        end
      end
      stalled = out_valid && !out_ready;
      prev_addr = cur_addr(); prev_sel = sel_o; prev_m1 = m1_out_0_o;
      step();
    end
    lag = (done_cyc >= 0 && last_acc_cyc >= 0) ? done_cyc - last_acc_cyc : -1;
    out_ready = 1'b0;
  endtask

  initial begin
    int acc, lag, dones;
    logic [47:0] first, mid, last;
    logic [15:0] m1;
    bit sel_ok, stable_ok;
    int guard;

    vecs[0] = '{3'd1, 8'd1, 1'b0, 6, 3, mk(0,6,12,18,24,0,0,0),
                mk(3,9,15,21,27,0,0,0), mk(5,11,17,23,29,0,0,0), 16'h0000};
    vecs[1] = '{3'd2, 8'd2, 1'b0, 10, 5, mk(0,5,10,15,20,25,30,35),
                mk(0,5,10,15,20,25,30,35), mk(4,9,14,19,24,29,34,39), 16'h0000};
    vecs[2] = '{3'd3, 8'd1, 1'b1, 12, 6, mk(0,12,24,36,48,0,0,0),
                mk(6,18,30,42,54,0,0,0), mk(11,23,35,47,59,0,0,0), 16'h0000};
    vecs[3] = '{3'd4, 8'd0, 1'b0, 2, 1, mk(0,0,0,0,0,0,0,0),
                mk(0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0), 16'h0002};
    vecs[4] = '{3'd5, 8'd1, 1'b0, 2, 1, mk(0,0,0,0,0,0,0,0),
                mk(0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0), 16'h0000};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; out_ready = 1'b0;
    mode = 3'd0; num_passes = '0;
    #22;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_sel", 64'(sel_o), 64'd0);
    chk("reset_addr", 64'(cur_addr()), 64'd0);
    chk("reset_done_err", 64'({done, err, m1_out_0_o}), 64'd0);
    rst_n = 1'b1;
    step();

    // Illegal mode: err pulse only.
    mode = 3'd6; num_passes = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk("err_pulse", 64'(err), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    chk("err_valid", 64'(out_valid), 64'd0);
    step();
    chk("err_one_cycle", 64'(err), 64'd0);

    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i], acc, first, mid, last, m1, sel_ok, stable_ok, lag, dones);
      chk($sformatf("job%0d_acc", i), 64'(acc), 64'(vecs[i].exp_acc));
      chk($sformatf("job%0d_first", i), 64'(first), 64'(vecs[i].exp_first));
      chk($sformatf("job%0d_mid", i), 64'(mid), 64'(vecs[i].exp_mid));
      chk($sformatf("job%0d_last", i), 64'(last), 64'(vecs[i].exp_last));
      chk($sformatf("job%0d_m1", i), 64'(m1), 64'(vecs[i].exp_m1));
      chk($sformatf("job%0d_sel", i), 64'(sel_ok), 64'd1);
      chk($sformatf("job%0d_stable", i), 64'(stable_ok), 64'd1);
      chk($sformatf("job%0d_done_lag", i), 64'(lag), 64'd1);
      chk($sformatf("job%0d_done_count", i), 64'(dones), 64'd1);
      chk($sformatf("job%0d_idle_after", i), 64'({busy, out_valid}), 64'd0);
      step();
    end

    // Flush at beat 3 of a mode 3 job, together with start and acceptance.
    mode = 3'd3; num_passes = 8'd1; start = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (!(out_valid && rd_addr0 == 6'd3) && guard < 20) begin
      step();
      guard++;
    end
    chk("flush_reach_beat3", 64'(rd_addr1), 64'd15);
    flush = 1'b1; start = 1'b1;
    step();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done_err", 64'({done, err}), 64'd0);
    chk("flush_addr", 64'(cur_addr()), 64'd0);
    flush = 1'b0; start = 1'b0; out_ready = 1'b0;
    step();
    chk("flush_stays_idle", 64'({busy, out_valid, done}), 64'd0);

    // Asynchronous reset in the middle of a job.
    mode = 3'd1; num_passes = 8'd1; start = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b1;
    step();
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid_busy", 64'({out_valid, busy}), 64'd0);
    chk("rst_async_sel", 64'(sel_o), 64'd0);
    chk("rst_async_addr", 64'(cur_addr()), 64'd0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b0;
    step();
    chk("rst_after_idle", 64'({out_valid, busy, done}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
